mmio_timer: RTL and testbench

Memory-mapped timer that is the responder on the CPU data-memory bus and the source of the CPU's external interrupt line. It decodes a small register window, answers loads combinationally in the same cycle, commits stores on the clock edge, and runs a prescaled 32-bit up-counter with compare match. The interrupt output connects directly to the core's interrupt input, and the read data is ORed with data-memory read data at the top level.

---
 rtl/mmio_timer_pkg.sv | 39 +++
 rtl/mmio_timer_if.sv | 12 +
 rtl/mmio_timer_prescaler.sv | 30 +++
 rtl/mmio_timer.sv | 123 ++++++++++++
 tb/tb_mmio_timer.sv | 189 ++++++++++++++++++
 5 files changed

// File: rtl/mmio_timer_pkg.sv
// Shared register map, CTRL/STATUS bit positions and CTRL layout for mmio_timer.
// Pure declarations: no latency, no flow control.
package mmio_timer_pkg;

    localparam int DIV_W = 8;

    // Byte offsets inside the 32-byte window
    localparam logic [4:0] REG_CTRL    = 5'h00;
    localparam logic [4:0] REG_STATUS  = 5'h04;
    localparam logic [4:0] REG_COUNT   = 5'h08;
    localparam logic [4:0] REG_COMPARE = 5'h0C;
    localparam logic [4:0] REG_COUNTH  = 5'h10;

    localparam int CTRL_EN      = 0;
    localparam int CTRL_IE      = 1;
    localparam int CTRL_AR      = 2;
    localparam int CTRL_DIV_LSB = 8;

    localparam int STATUS_PEND = 0;
    localparam int STATUS_EN   = 1;

    typedef struct packed {
        logic [DIV_W-1:0] div;
        logic             ar;
        logic             ie;
        logic             en;
    } ctrl_t;

    function automatic logic [31:0] ctrl_word(input ctrl_t c);
        logic [31:0] w;
        w                         = '0;
        w[CTRL_EN]                = c.en;
        w[CTRL_IE]                = c.ie;
        w[CTRL_AR]                = c.ar;
        w[CTRL_DIV_LSB +: DIV_W]  = c.div;
        return w;
    endfunction

endpackage

// File: rtl/mmio_timer_if.sv
// CPU data-bus / interrupt bundle between the core (master) and mmio_timer (slave).
// Loads answer combinationally; stores commit on the clock edge; no backpressure.
interface mmio_timer_if;
    logic        I_memrw;
    logic [31:0] I_address;
    logic [31:0] I_data;
    logic [31:0] O_data;
    logic        O_interrupt;

    modport master (output I_memrw, I_address, I_data, input  O_data, O_interrupt);
    modport slave  (input  I_memrw, I_address, I_data, output O_data, O_interrupt);
endinterface

// File: rtl/mmio_timer_prescaler.sv
// Prescaler: pulses tick once every div+1 cycles while enabled.
// tick is combinational from the pcnt flop; no backpressure.
module mmio_timer_prescaler
    import mmio_timer_pkg::*;
(
    input  logic             I_clk,
    input  logic             I_rst,
    input  logic             enable,
    input  logic [DIV_W-1:0] div,
    input  logic             clear,
    output logic             tick
);

    logic [DIV_W-1:0] pcnt;
    logic             wrap;

    assign wrap = (pcnt == div);
    assign tick = enable && wrap;

    always_ff @(posedge I_clk or negedge I_rst) begin
        if (!I_rst) begin
            pcnt <= '0;
        end else if (!enable || clear || wrap) begin
            pcnt <= '0;
        end else begin
            pcnt <= pcnt + DIV_W'(1);
        end
    end

endmodule

// File: rtl/mmio_timer.sv
// Memory-mapped prescaled 32-bit timer with compare-match interrupt (COUNTH via MMIO_TIMER_COUNTH_EN).
// Loads combinational (0 cycles), stores commit on the edge, interrupt registered.
// No backpressure: every bus access completes in the cycle it is presented.
module mmio_timer
    import mmio_timer_pkg::*;
#(
    parameter logic [31:0] BASE      = 32'h0001_0000,
    parameter logic [31:0] RESET_CMP = 32'hFFFF_FFFF
)
(
    input  logic         I_clk,
    input  logic         I_rst,
    mmio_timer_if.slave  bus
);

    logic        hit;
    logic [4:0]  reg_off;
    logic        wr;
    logic        wr_ctrl, wr_status, wr_count, wr_compare;
    logic        tick, match;
    ctrl_t       ctrl;
    logic        pend;
    logic [31:0] count, compare, counth_rd;
    logic        unused_addr_lsbs;

    assign hit              = (bus.I_address[31:5] == BASE[31:5]);
    assign reg_off          = {bus.I_address[4:2], 2'b00};
    assign unused_addr_lsbs = ^bus.I_address[1:0];
    assign wr               = bus.I_memrw && hit;
    assign wr_ctrl          = wr && (reg_off == REG_CTRL);
    assign wr_status        = wr && (reg_off == REG_STATUS);
    assign wr_count         = wr && (reg_off == REG_COUNT);
    assign wr_compare       = wr && (reg_off == REG_COMPARE);

    // A COUNT store restarts the prescale period along with the count
    mmio_timer_prescaler u_prescaler (
        .I_clk  (I_clk),
        .I_rst  (I_rst),
        .enable (ctrl.en),
        .div    (ctrl.div),
        .clear  (wr_count),
        .tick   (tick)
    );

    assign match = tick && (count == compare);

    always_ff @(posedge I_clk or negedge I_rst) begin
        if (!I_rst) begin
            ctrl <= '0;
        end else if (wr_ctrl) begin
            ctrl.en  <= bus.I_data[CTRL_EN];
            ctrl.ie  <= bus.I_data[CTRL_IE];
            ctrl.ar  <= bus.I_data[CTRL_AR];
            ctrl.div <= bus.I_data[CTRL_DIV_LSB +: DIV_W];
        end
    end

    always_ff @(posedge I_clk or negedge I_rst) begin
        if (!I_rst) begin
            count   <= '0;
            compare <= RESET_CMP;
            pend    <= 1'b0;
        end else begin
            if (wr_count)
                count <= bus.I_data;
            else if (tick)
                count <= (match && ctrl.ar) ? 32'd0 : count + 32'd1;

            if (wr_compare)
                compare <= bus.I_data;

            // Set beats write-1-to-clear in the same cycle
            if (match)
                pend <= 1'b1;
            else if (wr_status && bus.I_data[STATUS_PEND])
                pend <= 1'b0;
        end
    end

`ifdef MMIO_TIMER_COUNTH_EN
    logic [31:0] counth;
    logic        wr_counth;

    assign wr_counth = wr && (reg_off == REG_COUNTH);

    always_ff @(posedge I_clk or negedge I_rst) begin
        if (!I_rst) begin
            counth <= '0;
        end else if (wr_counth) begin
            counth <= bus.I_data;
        end else if (tick && !wr_count) begin
            if (match && ctrl.ar)
                counth <= '0;
            else if (count == 32'hFFFF_FFFF)
                counth <= counth + 32'd1;
        end
    end

    assign counth_rd = counth;
`else
    assign counth_rd = '0;
`endif

    always_comb begin
        bus.O_data = '0;
        if (hit) begin
            case (reg_off)
                REG_CTRL:    bus.O_data = ctrl_word(ctrl);
                REG_STATUS: begin
                    bus.O_data[STATUS_PEND] = pend;
                    bus.O_data[STATUS_EN]   = ctrl.en;
                end
                REG_COUNT:   bus.O_data = count;
                REG_COMPARE: bus.O_data = compare;
                REG_COUNTH:  bus.O_data = counth_rd;
                default:     bus.O_data = '0;
            endcase
        end
    end

    assign bus.O_interrupt = pend && ctrl.ie;

endmodule

// File: tb/tb_mmio_timer.sv
// Directed bench for mmio_timer: reset map, periodic match, auto-reload, wrap/collisions, async reset.
module tb_mmio_timer;

    localparam logic [31:0] BASE = 32'h0001_0000;

    logic I_clk = 1'b0;
    logic I_rst = 1'b0;
    int   checks = 0;
    int   errors = 0;

    mmio_timer_if bus();

    mmio_timer #(.BASE(BASE), .RESET_CMP(32'hFFFF_FFFF)) dut (
        .I_clk (I_clk),
        .I_rst (I_rst),
        .bus   (bus.slave)
    );

    always #5 I_clk = ~I_clk;

`ifdef MMIO_TIMER_COUNTH_EN
    localparam logic [31:0] EXP_COUNTH = 32'd1;
`else
    localparam logic [31:0] EXP_COUNTH = 32'd0;
`endif

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h exp %h", tag, got, exp);
        end
    endtask

    task automatic rd_abs(input logic [31:0] addr, output logic [31:0] v);
        bus.I_memrw   = 1'b0;
        bus.I_address = addr;
        #1;
        v = bus.O_data;
    endtask

    task automatic chk_rd(input string tag, input logic [4:0] off, input logic [31:0] exp);
        logic [31:0] v;
        rd_abs(BASE + {27'b0, off}, v);
        check(tag, v, exp);
    endtask

    task automatic chk_irq(input string tag, input logic [31:0] exp);
        check(tag, {31'b0, bus.O_interrupt}, exp);
    endtask

    task automatic wr(input logic [4:0] off, input logic [31:0] d);
        @(negedge I_clk);
        bus.I_memrw   = 1'b1;
        bus.I_address = BASE + {27'b0, off};
        bus.I_data    = d;
        @(posedge I_clk);
        #1;
        bus.I_memrw = 1'b0;
        bus.I_data  = '0;
    endtask

    task automatic do_reset();
        @(negedge I_clk);
        I_rst = 1'b0;
        #2;
        I_rst = 1'b1;
    endtask

    initial begin
        logic [31:0] v;
        bus.I_memrw   = 1'b0;
        bus.I_address = '0;
        bus.I_data    = '0;
        repeat (2) @(posedge I_clk);
        @(negedge I_clk);
        I_rst = 1'b1;

        // Reset map
        for (int i = 0; i < 8; i++) begin
            logic [4:0] off;
            off = 5'(i * 4);
            chk_rd($sformatf("rst_off%0h", off), off, (off == 5'h0C) ? 32'hFFFF_FFFF : 32'd0);
        end
        rd_abs(32'h0002_0000, v);
        check("rst_miss", v, 32'd0);
        chk_irq("rst_irq", 32'd0);

        // Periodic tick, DIV=3
        wr(5'h0C, 32'd5);
        wr(5'h08, 32'd4);
        wr(5'h00, 32'h0000_0303);
        chk_rd("per_cnt_e0", 5'h08, 32'd4);
        chk_rd("per_ctrl", 5'h00, 32'h0000_0303);
        repeat (3) @(posedge I_clk);
        #2;
        chk_rd("per_cnt_e3", 5'h08, 32'd4);
        @(posedge I_clk);
        #2;
        chk_rd("per_cnt_e4", 5'h08, 32'd5);
        chk_rd("per_stat_e4", 5'h04, 32'h2);
        repeat (3) @(posedge I_clk);
        #2;
        chk_rd("per_cnt_e7", 5'h08, 32'd5);
        chk_irq("per_irq_e7", 32'd0);
        @(posedge I_clk);
        #2;
        chk_rd("per_cnt_e8", 5'h08, 32'd6);
        chk_rd("per_stat_e8", 5'h04, 32'h3);
        chk_irq("per_irq_e8", 32'd1);

        // Auto-reload, DIV=0, COMPARE=2
        do_reset();
        wr(5'h0C, 32'd2);
        wr(5'h00, 32'h0000_0007);
        chk_rd("ar_cnt_0", 5'h08, 32'd0);
        for (int k = 1; k <= 6; k++) begin
            @(posedge I_clk);
            #2;
            chk_rd($sformatf("ar_cnt_%0d", k), 5'h08, 32'(k % 3));
            chk_irq($sformatf("ar_irq_%0d", k), (k >= 3) ? 32'd1 : 32'd0);
        end
        wr(5'h04, 32'd1);
        #1;
        chk_irq("ar_clr_irq", 32'd0);
        chk_rd("ar_clr_stat", 5'h04, 32'h2);
        @(posedge I_clk);
        #2;
        chk_irq("ar_irq_e8", 32'd0);
        @(posedge I_clk);
        #2;
        chk_irq("ar_irq_e9", 32'd1);

        // Wrap and collisions
        do_reset();
        wr(5'h08, 32'hFFFF_FFFE);
        wr(5'h00, 32'h0000_0001);
        chk_rd("wr_cnt_e0", 5'h08, 32'hFFFF_FFFE);
        @(posedge I_clk);
        #2;
        chk_rd("wr_cnt_e1", 5'h08, 32'hFFFF_FFFF);
        @(posedge I_clk);
        #2;
        chk_rd("wr_cnt_e2", 5'h08, 32'd0);
        chk_rd("wr_counth", 5'h10, EXP_COUNTH);
        chk_rd("wr_stat", 5'h04, 32'h3);
        wr(5'h00, 32'h0);
        wr(5'h04, 32'd1);
        wr(5'h0C, 32'h12);
        wr(5'h08, 32'h11);
        chk_rd("col_stat_idle", 5'h04, 32'h0);
        wr(5'h00, 32'h0000_0001);
        @(posedge I_clk);
        wr(5'h04, 32'd1);
        chk_rd("col_stat_set", 5'h04, 32'h3);
        chk_rd("col_cnt", 5'h08, 32'h13);
        wr(5'h08, 32'h10);
        chk_rd("col_cnt_store", 5'h08, 32'h10);
        @(posedge I_clk);
        #2;
        chk_rd("col_cnt_next", 5'h08, 32'h11);
        chk_rd("col_counth", 5'h10, EXP_COUNTH);

        // Asynchronous reset while interrupting
        wr(5'h00, 32'h0000_0003);
        #1;
        chk_irq("ars_irq_hi", 32'd1);
        @(negedge I_clk);
        #2;
        I_rst = 1'b0;
        #1;
        chk_irq("ars_irq_lo", 32'd0);
        chk_rd("ars_cnt_in", 5'h08, 32'd0);
        @(negedge I_clk);
        I_rst = 1'b1;
        @(posedge I_clk);
        #2;
        chk_rd("ars_ctrl", 5'h00, 32'd0);
        chk_rd("ars_cmp", 5'h0C, 32'hFFFF_FFFF);
        repeat (3) @(posedge I_clk);
        #2;
        chk_rd("ars_cnt", 5'h08, 32'd0);
        chk_irq("ars_irq_end", 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
